// File: rtl/brg_ps2wb_rfifo.sv
// PSRAM-to-Wishbone read FIFO: RAM storage with a registered read, followed by a first-word-fall-through output stage.
// Optional macro BRG_RFIFO_ERR_EN enables the sticky overflow/underflow flag on err.
module brg_ps2wb_rfifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  ps_rvalid,
  input  logic [DATA_WIDTH-1:0] ps_rdata,
  output logic                  ps_rready,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  full_s, empty_s, push_s, rd_en_s;

  // Pointers differ only in the wrap bit when every RAM entry is occupied.
  assign full_s  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign push_s  = ps_rvalid && !full_s && !flush;

  assign ps_rready  = !full_s;
  assign level      = wr_ptr_q - rd_ptr_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;

  // Output-stage next state, read issue and head-word capture.
  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    rd_en_s      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (!empty_s) begin
          rd_en_s = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FETCH: begin
        dout_d       = rdata_q;
        dout_valid_d = 1'b1;
        state_d      = ST_VALID;
      end
      ST_VALID: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          if (!empty_s) begin
            rd_en_s = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          dout_valid_d = 1'b1;
          state_d      = ST_VALID;
        end
      end
      default: begin
        dout_valid_d = 1'b0;
        state_d      = ST_EMPTY;
      end
    endcase
    // Flush wins over any same-cycle read issue or pop.
    if (flush) begin
      state_d      = ST_EMPTY;
      dout_valid_d = 1'b0;
      dout_d       = '0;
      rd_en_s      = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Pointer update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= ST_EMPTY;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Storage RAM: one write port, one registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= ps_rdata;
    end
    if (rd_en_s) begin
      rdata_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

`ifdef BRG_RFIFO_ERR_EN
  logic err_q, err_d;

  // Sticky overflow/underflow detection, cleared only by flush or reset.
  always_comb begin
    if (flush) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q | (ps_rvalid & full_s) | (dout_ready & !dout_valid_q);
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_brg_ps2wb_rfifo.sv
// Scoreboard bench for brg_ps2wb_rfifo: accepted pushes queue expected words, a negedge monitor checks pops and occupancy.
module tb_brg_ps2wb_rfifo;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn, flush, ps_rvalid, ps_rready, dout_valid, dout_ready, err;
  logic [DW-1:0] ps_rdata, dout;
  logic [AW:0]   level;

  int            errors = 0;
  int            checks = 0;
  int            pops   = 0;
  int            mon_diff;
  logic [DW-1:0] exp_q[$];
  logic          pend_push, pend_flush, prev_pop;
  logic [DW-1:0] pend_data;
  logic          err_en;

  always #5 clk = ~clk;

  brg_ps2wb_rfifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .ps_rvalid(ps_rvalid), .ps_rdata(ps_rdata),
    .ps_rready(ps_rready), .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
    .level(level), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One clock of stimulus; the previous cycle's accepted push or flush lands in the model at this edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f, output logic acc);
    @(posedge clk);
    if (pend_flush) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_data);
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    #1;
    ps_rvalid = v; ps_rdata = d; dout_ready = r; flush = f;
    @(negedge clk);
    acc        = v && ps_rready && !f;
    pend_push  = acc;
    pend_data  = d;
    pend_flush = f;
  endtask

  task automatic idle(input int n, input logic r);
    logic a;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, r, 1'b0, a);
  endtask

  task automatic drain();
    logic a;
    int   k = 0;
    while ((exp_q.size() != 0 || pend_push) && k < 300) begin
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      k++;
    end
    idle(2, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; flush = 1'b0; ps_rvalid = 1'b0; ps_rdata = '0; dout_ready = 1'b0;
    exp_q.delete();
    pend_push = 1'b0; pend_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Monitor: occupancy model, pop spacing and in-order data.
  always @(negedge clk) begin
    if (resetn) begin
      mon_diff = exp_q.size() - int'(level);
      if (dout_valid) begin
        chk("occupancy_valid", mon_diff, 1);
        chk("ps_rready_vs_model", ps_rready, (exp_q.size() - 1) < DEPTH);
      end else if (mon_diff < 0 || mon_diff > 1) begin
        chk("occupancy_idle", mon_diff, 0);
      end
      if (prev_pop) chk("pop_gap", dout_valid, 1'b0);
      if (dout_valid && dout_ready && !flush) begin
        if (exp_q.size() == 0) chk("unexpected_pop", dout, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("dout_data", dout, exp_q.pop_front());
        pops++;
        prev_pop = 1'b1;
      end else begin
        prev_pop = 1'b0;
      end
    end else begin
      prev_pop = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    int   n, p0;
`ifdef BRG_RFIFO_ERR_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif
    prev_pop = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_ps_rready", ps_rready, 1'b1);
    chk("rst_level", level, 0);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_dout", dout, 0);
    chk("rst_err", err, 1'b0);

    // Single word: two-cycle fall-through latency.
    cyc(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, a);
    chk("t1_accept", a, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, a);
    chk("t1_level_after_push", level, 1);
    chk("t1_dv_n", dout_valid, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, a);
    chk("t1_level_fetch", level, 0);
    chk("t1_dv_n1", dout_valid, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, a);
    chk("t1_dv_n2", dout_valid, 1'b1);
    chk("t1_dout", dout, 32'hA5A5_0001);
    cyc(1'b0, '0, 1'b1, 1'b0, a);
    chk("t1_dv_after_pop", dout_valid, 1'b0);
    chk("t1_level_end", level, 0);

    // Fill: 17 words (one in output stage, 16 stored), 18th rejected.
    n = 0;
    for (int i = 1; i <= 17; i++) begin
      cyc(1'b1, 32'h3200_0000 + i, 1'b0, 1'b0, a);
      if (a) n++;
    end
    chk("fill_accepted", n, 17);
    idle(3, 1'b0);
    chk("fill_level", level, DEPTH);
    chk("fill_ps_rready", ps_rready, 1'b0);
    chk("fill_dv", dout_valid, 1'b1);
    chk("fill_head", dout, 32'h3200_0001);
    cyc(1'b1, 32'h3200_00FF, 1'b0, 1'b0, a);
    chk("overflow_rejected", a, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, a);
    chk("overflow_level", level, DEPTH);
    chk("overflow_err", err, err_en);
    p0 = pops;
    drain();
    chk("fill_pops", pops - p0, 17);
    chk("err_sticky", err, err_en);
    cyc(1'b0, '0, 1'b0, 1'b1, a);
    cyc(1'b0, '0, 1'b0, 1'b0, a);
    chk("err_after_flush", err, 1'b0);

    // Stream 40 words with dout_ready held, across pointer wrap.
    n = 0; p0 = pops;
    for (int k = 0; k < 400 && n < 40; k++) begin
      cyc(1'b1, 32'h3300_0000 + n, 1'b1, 1'b0, a);
      if (a) n++;
    end
    chk("stream_accepted", n, 40);
    drain();
    chk("stream_pops", pops - p0, 40);

    // Flush together with push and pop.
    cyc(1'b0, '0, 1'b0, 1'b1, a);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h3400_0000 + i, 1'b0, 1'b0, a);
    idle(3, 1'b0);
    cyc(1'b1, 32'h0000_DEAD, 1'b1, 1'b1, a);
    cyc(1'b0, '0, 1'b0, 1'b0, a);
    chk("flush_level", level, 0);
    chk("flush_dv", dout_valid, 1'b0);
    chk("flush_ps_rready", ps_rready, 1'b1);
    chk("flush_err", err, 1'b0);
    p0 = pops;
    cyc(1'b1, 32'h0000_1234, 1'b1, 1'b0, a);
    drain();
    chk("flush_next_pops", pops - p0, 1);

    // Reset asserted during FETCH with three words stored.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h3500_0000 + i, 1'b0, 1'b0, a);
    idle(3, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, a);
    cyc(1'b0, '0, 1'b0, 1'b0, a);
    chk("pre_reset_level", level, 3);
    chk("pre_reset_dv", dout_valid, 1'b0);
    #1 resetn = 1'b0;
    exp_q.delete();
    pend_push = 1'b0; pend_flush = 1'b0;
    #1;
    chk("async_rst_dv", dout_valid, 1'b0);
    chk("async_rst_level", level, 0);
    chk("async_rst_err", err, 1'b0);
    chk("async_rst_ps_rready", ps_rready, 1'b1);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 500; k++) begin
      cyc(($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 79) == 0), a);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, a);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
